// File: rtl/controle_turno_pkg.sv
// Shared definitions for the naval-battle turn sequencer: FSM state encoding,
// default game constants and datapath widths.
package controle_turno_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    VERIFICA  = 2'd1,
    RESULTADO = 2'd2,
    FIM       = 2'd3
  } estado_t;

  localparam int TOTAL_PECAS_DEF = 17;
  localparam int COORD_MAX_DEF   = 9;
  localparam int TIMEOUT_DEF     = 16;

  localparam int ACERTO_W = 5;
  localparam int COORD_W  = 4;

endpackage

// File: rtl/controle_turno_placar.sv
// Score keeper: one saturating hit counter per player, plus the end-of-game
// detection that latches the winner when a fleet is fully sunk.
module controle_turno_placar
  import controle_turno_pkg::*;
#(
  parameter int TOTAL_PECAS = TOTAL_PECAS_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                incremento,
  input  logic                atirador,
  output logic [ACERTO_W-1:0] acertos_p1,
  output logic [ACERTO_W-1:0] acertos_p2,
  output logic                completa,
  output logic                fim,
  output logic                vencedor
);

  logic [ACERTO_W-1:0] atual;

  // completa flags that the pending increment is the one that sinks the last cell,
  // so the sequencer can branch to FIM in the same cycle.
  always_comb begin
    atual    = atirador ? acertos_p2 : acertos_p1;
    completa = incremento && (atual == ACERTO_W'(TOTAL_PECAS - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acertos_p1 <= '0;
      acertos_p2 <= '0;
      fim        <= 1'b0;
      vencedor   <= 1'b0;
    end else begin
      if (incremento && (atual != ACERTO_W'(TOTAL_PECAS))) begin
        if (atirador) begin
          acertos_p2 <= acertos_p2 + ACERTO_W'(1);
        end else begin
          acertos_p1 <= acertos_p1 + ACERTO_W'(1);
        end
      end
      if (completa && !fim) begin
        fim      <= 1'b1;
        vencedor <= atirador;
      end
    end
  end

endmodule

// File: rtl/controle_turno.sv
// Turn sequencer: validates shots, drives the collision checker, scores hits and
// decides the next shooter. REPETE_ACERTO_EN lets a player keep the turn after a hit.
module controle_turno
  import controle_turno_pkg::*;
#(
  parameter int TOTAL_PECAS = TOTAL_PECAS_DEF,
  parameter int COORD_MAX   = COORD_MAX_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tiro_valido,
  input  logic [COORD_W-1:0]  x,
  input  logic [COORD_W-1:0]  y,
  output logic                tiro_aceito,
  output logic                tiro_invalido,
  output logic                col_enable,
  output logic [COORD_W-1:0]  col_x,
  output logic [COORD_W-1:0]  col_y,
  output logic                col_jogador,
  input  logic                col_ready,
  input  logic                col_hit,
  output logic                jogador_atual,
  output logic                resultado_valido,
  output logic                resultado_hit,
  output logic [ACERTO_W-1:0] acertos_p1,
  output logic [ACERTO_W-1:0] acertos_p2,
  output logic                fim_jogo,
  output logic                vencedor
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  estado_t          estado;
  estado_t          estado_prox;
  logic [CNT_W-1:0] cnt;
  logic             hit_reg;
  logic             aceita;
  logic             rejeita;
  logic             pronto;
  logic             expirou;
  logic             completa;

  assign col_enable       = (estado == VERIFICA);
  assign resultado_valido = (estado == RESULTADO);
  assign resultado_hit    = resultado_valido && hit_reg;

  // The checker keeps ready asserted from the previous shot, so it only counts
  // once the timeout counter has moved past the first VERIFICA cycle.
  always_comb begin
    estado_prox = estado;
    aceita      = 1'b0;
    rejeita     = 1'b0;
    pronto      = 1'b0;
    expirou     = 1'b0;
    case (estado)
      OCIOSO: begin
        if (tiro_valido) begin
          if ((x > COORD_W'(COORD_MAX)) || (y > COORD_W'(COORD_MAX))) begin
            rejeita = 1'b1;
          end else begin
            aceita      = 1'b1;
            estado_prox = VERIFICA;
          end
        end
      end
      VERIFICA: begin
        pronto  = col_ready && (cnt != '0);
        expirou = (cnt == CNT_W'(TIMEOUT));
        if (pronto || expirou) begin
          estado_prox = RESULTADO;
        end
      end
      RESULTADO: begin
        estado_prox = completa ? FIM : OCIOSO;
      end
      FIM: begin
        estado_prox = FIM;
      end
      default: begin
        estado_prox = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado        <= OCIOSO;
      tiro_aceito   <= 1'b0;
      tiro_invalido <= 1'b0;
      col_x         <= '0;
      col_y         <= '0;
      col_jogador   <= 1'b0;
      cnt           <= '0;
      hit_reg       <= 1'b0;
      jogador_atual <= 1'b0;
    end else begin
      estado        <= estado_prox;
      tiro_aceito   <= aceita;
      tiro_invalido <= rejeita;
      if (aceita) begin
        col_x       <= x;
        col_y       <= y;
        col_jogador <= ~jogador_atual;
        cnt         <= '0;
        hit_reg     <= 1'b0;
      end else if (estado == VERIFICA) begin
        cnt <= cnt + CNT_W'(1);
        if (pronto) begin
          hit_reg <= col_hit;
        end
      end
      // Turn rule; the winner keeps the turn once the game ends.
      if ((estado == RESULTADO) && !completa) begin
`ifdef REPETE_ACERTO_EN
        if (!hit_reg) begin
          jogador_atual <= ~jogador_atual;
        end
`else
        jogador_atual <= ~jogador_atual;
`endif
      end
    end
  end

  controle_turno_placar #(
    .TOTAL_PECAS (TOTAL_PECAS)
  ) u_placar (
    .clk        (clk),
    .reset_n    (reset_n),
    .incremento (resultado_hit),
    .atirador   (jogador_atual),
    .acertos_p1 (acertos_p1),
    .acertos_p2 (acertos_p2),
    .completa   (completa),
    .fim        (fim_jogo),
    .vencedor   (vencedor)
  );

endmodule

// File: tb/tb_controle_turno.sv
// Self-checking bench for controle_turno: a reference model pushes expected shot
// results to a queue; they are popped and compared when resultado_valido fires.
module tb_controle_turno;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tiro_valido;
  logic [3:0] x;
  logic [3:0] y;
  logic       tiro_aceito;
  logic       tiro_invalido;
  logic       col_enable;
  logic [3:0] col_x;
  logic [3:0] col_y;
  logic       col_jogador;
  logic       col_ready;
  logic       col_hit;
  logic       jogador_atual;
  logic       resultado_valido;
  logic       resultado_hit;
  logic [4:0] acertos_p1;
  logic [4:0] acertos_p2;
  logic       fim_jogo;
  logic       vencedor;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       hit;
    logic [4:0] p1;
    logic [4:0] p2;
    logic       jog;
    logic       fim;
    logic       venc;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] m_p1;
  logic [4:0] m_p2;
  logic       m_jog;
  logic       m_fim;
  logic       m_venc;

  controle_turno dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .tiro_valido      (tiro_valido),
    .x                (x),
    .y                (y),
    .tiro_aceito      (tiro_aceito),
    .tiro_invalido    (tiro_invalido),
    .col_enable       (col_enable),
    .col_x            (col_x),
    .col_y            (col_y),
    .col_jogador      (col_jogador),
    .col_ready        (col_ready),
    .col_hit          (col_hit),
    .jogador_atual    (jogador_atual),
    .resultado_valido (resultado_valido),
    .resultado_hit    (resultado_hit),
    .acertos_p1       (acertos_p1),
    .acertos_p2       (acertos_p2),
    .fim_jogo         (fim_jogo),
    .vencedor         (vencedor)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_p1   = '0;
    m_p2   = '0;
    m_jog  = 1'b0;
    m_fim  = 1'b0;
    m_venc = 1'b0;
    sb.delete();
  endtask

  // Reference game rules: score the shooter, detect a sunk fleet, pass the turn.
  task automatic push_expected(input logic hit);
    exp_t e;
    if (hit) begin
      if (m_jog) m_p2 = m_p2 + 5'd1;
      else       m_p1 = m_p1 + 5'd1;
    end
    if (hit && ((m_jog ? m_p2 : m_p1) == 5'd17)) begin
      m_fim  = 1'b1;
      m_venc = m_jog;
    end else begin
`ifdef REPETE_ACERTO_EN
      if (!hit) m_jog = ~m_jog;
`else
      m_jog = ~m_jog;
`endif
    end
    e.hit  = hit;
    e.p1   = m_p1;
    e.p2   = m_p2;
    e.jog  = m_jog;
    e.fim  = m_fim;
    e.venc = m_venc;
    sb.push_back(e);
  endtask

  task automatic start_shot(input logic [3:0] sx, input logic [3:0] sy, input bit hold);
    tiro_valido = 1'b1;
    x = sx;
    y = sy;
    @(posedge clk); #1;
    checks++;
    if (!(tiro_aceito === 1'b1 && col_enable === 1'b1)) begin
      errors++;
      $display("[TB] FAIL accept (%0d,%0d): aceito=%b col_enable=%b want 1 1", sx, sy, tiro_aceito, col_enable);
    end
    checks++;
    if ({col_x, col_y, col_jogador} !== {sx, sy, ~m_jog}) begin
      errors++;
      $display("[TB] FAIL col_latch: x=%0d y=%0d jog=%b want x=%0d y=%0d jog=%b",
               col_x, col_y, col_jogador, sx, sy, ~m_jog);
    end
    if (!hold) tiro_valido = 1'b0;
  endtask

  // Called in the first VERIFICA cycle; ready_k=0 means the checker never answers.
  task automatic resolve_shot(input int ready_k, input bit stale, input bit hit, input bit hold);
    exp_t e;
    int   cyc;
    int   exp_lat;
    int   aceitos;
    bit   seen;
    push_expected((ready_k != 0) ? hit : 1'b0);
    exp_lat = (ready_k != 0) ? ready_k : 17;
    cyc = 0;
    aceitos = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      col_ready = ((ready_k != 0) && (cyc + 1 == ready_k)) || (stale && cyc == 0);
      col_hit   = col_ready ? (stale ? 1'b1 : hit) : 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (tiro_aceito === 1'b1) aceitos++;
      seen = (resultado_valido === 1'b1);
    end
    col_ready = 1'b0;
    col_hit   = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!seen || cyc != exp_lat) begin
      errors++;
      $display("[TB] FAIL latency: got %0d cycles (seen=%0b) want %0d", cyc, seen, exp_lat);
    end
    checks++;
    if (resultado_hit !== e.hit) begin
      errors++;
      $display("[TB] FAIL resultado_hit: got %b want %b", resultado_hit, e.hit);
    end
    checks++;
    if (aceitos != 0) begin
      errors++;
      $display("[TB] FAIL extra_accept: got %0d pulses want 0 (hold=%0b)", aceitos, hold);
    end
    @(posedge clk); #1;
    checks++;
    if ({acertos_p1, acertos_p2} !== {e.p1, e.p2}) begin
      errors++;
      $display("[TB] FAIL counters: p1=%0d p2=%0d want p1=%0d p2=%0d", acertos_p1, acertos_p2, e.p1, e.p2);
    end
    checks++;
    if ({jogador_atual, fim_jogo, resultado_valido, col_enable} !== {e.jog, e.fim, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL post_state: jog=%b fim=%b valid=%b en=%b want %b %b 0 0",
               jogador_atual, fim_jogo, resultado_valido, col_enable, e.jog, e.fim);
    end
    if (e.fim) begin
      checks++;
      if (vencedor !== e.venc) begin
        errors++;
        $display("[TB] FAIL vencedor: got %b want %b", vencedor, e.venc);
      end
    end
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    tiro_valido = 1'b0;
    col_ready   = 1'b0;
    col_hit     = 1'b0;
    x = 4'd0;
    y = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({tiro_aceito, tiro_invalido, col_enable, resultado_valido, resultado_hit, fim_jogo, vencedor} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b want 0000000",
               {tiro_aceito, tiro_invalido, col_enable, resultado_valido, resultado_hit, fim_jogo, vencedor});
    end
    checks++;
    if ({col_x, col_y, col_jogador, jogador_atual, acertos_p1, acertos_p2} !== 20'b0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got %h want 0",
               {col_x, col_y, col_jogador, jogador_atual, acertos_p1, acertos_p2});
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_hit_shot();
    start_shot(4'd3, 4'd4, 1'b0);
    resolve_shot(3, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_invalid();
    logic [3:0] bad_x[3] = '{4'd10, 4'd2, 4'd15};
    logic [3:0] bad_y[3] = '{4'd2, 4'd10, 4'd15};
    for (int i = 0; i < 3; i++) begin
      tiro_valido = 1'b1;
      x = bad_x[i];
      y = bad_y[i];
      @(posedge clk); #1;
      tiro_valido = 1'b0;
      checks++;
      if ({tiro_invalido, tiro_aceito, col_enable} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL invalid (%0d,%0d): inv/acc/en=%b want 100", x, y, {tiro_invalido, tiro_aceito, col_enable});
      end
      @(posedge clk); #1;
      checks++;
      if ({tiro_invalido, col_enable, jogador_atual} !== {2'b00, m_jog}) begin
        errors++;
        $display("[TB] FAIL invalid_after: inv/en/jog=%b want 00%b", {tiro_invalido, col_enable, jogador_atual}, m_jog);
      end
    end
  endtask

  task automatic test_boundary();
    start_shot(4'd9, 4'd9, 1'b0);
    resolve_shot(2, 1'b0, 1'b0, 1'b0);
    start_shot(4'd0, 4'd0, 1'b0);
    resolve_shot(2, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_stale_timeout();
    start_shot(4'd5, 4'd5, 1'b0);
    resolve_shot(0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    start_shot(4'd1, 4'd2, 1'b1);
    resolve_shot(2, 1'b0, 1'b1, 1'b1);
    checks++;
    if (tiro_aceito !== 1'b0) begin
      errors++;
      $display("[TB] FAIL early_accept: got %b want 0", tiro_aceito);
    end
    @(posedge clk); #1;
    tiro_valido = 1'b0;
    checks++;
    if ({tiro_aceito, col_enable, col_jogador} !== {2'b11, ~m_jog}) begin
      errors++;
      $display("[TB] FAIL second_accept: acc/en/jog=%b want 11%b", {tiro_aceito, col_enable, col_jogador}, ~m_jog);
    end
    resolve_shot(4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    start_shot(4'd6, 4'd7, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({tiro_aceito, tiro_invalido, col_enable, resultado_valido, resultado_hit, fim_jogo, vencedor} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL midreset_flags: got %b want 0000000",
               {tiro_aceito, tiro_invalido, col_enable, resultado_valido, resultado_hit, fim_jogo, vencedor});
    end
    checks++;
    if ({col_x, col_y, col_jogador, jogador_atual, acertos_p1, acertos_p2} !== 20'b0) begin
      errors++;
      $display("[TB] FAIL midreset_regs: got %h want 0",
               {col_x, col_y, col_jogador, jogador_atual, acertos_p1, acertos_p2});
    end
    reset_n = 1'b1;
    model_reset();
    start_shot(4'd6, 4'd7, 1'b0);
    resolve_shot(2, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_game_over();
    int shots;
    test_reset();
    shots = 0;
    while (m_p2 < 5'd17 && shots < 60) begin
      start_shot(4'd1, 4'd1, 1'b0);
      resolve_shot(2, 1'b0, m_jog, 1'b0);
      shots++;
    end
    checks++;
    if ({fim_jogo, vencedor, acertos_p2, acertos_p1} !== {2'b11, 5'd17, 5'd0}) begin
      errors++;
      $display("[TB] FAIL game_over: fim=%b venc=%b p2=%0d p1=%0d want 1 1 17 0",
               fim_jogo, vencedor, acertos_p2, acertos_p1);
    end
    tiro_valido = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = (i < 3) ? 4'd2 : 4'd12;
      y = 4'd3;
      @(posedge clk); #1;
      checks++;
      if ({tiro_aceito, tiro_invalido, col_enable, resultado_valido, fim_jogo} !== 5'b00001) begin
        errors++;
        $display("[TB] FAIL fim_absorb: acc/inv/en/val/fim=%b want 00001",
                 {tiro_aceito, tiro_invalido, col_enable, resultado_valido, fim_jogo});
      end
    end
    tiro_valido = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_hit_shot();
    test_invalid();
    test_boundary();
    test_stale_timeout();
    test_back_to_back();
    test_reset_mid();
    test_game_over();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
